// File: rtl/spi_led_slave.sv
// SPI mode-0 slave exposing a small register file (ID, LED, scratch, frame counter).
// Inputs are oversampled on CLOCK_50; every frame is a command byte followed by a data byte.
module spi_led_slave #(
  parameter int         NUM_REGS    = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] LED_RESET   = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       SPI_SCLK,
  input  logic       SPI_MOSI,
  input  logic       SPI_SS_N,
  output logic       SPI_MISO,
  output logic [7:0] LED,
  output logic       WR_STROBE,
  output logic [6:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       FRAME_ERR
);

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);
  localparam int         SETTLE     = SYNC_STAGES + 1;
  localparam int         SW         = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic [SYNC_STAGES-1:0] ssSync_q;
  logic                   sclkPrev_q;
  logic                   ssPrev_q;
  logic [SW-1:0]          settleCnt_q;
  logic                   armed_q;

  logic sclkS;
  logic mosiS;
  logic ssS;
  logic sclkRise;
  logic sclkFall;
  logic ssRise;
  logic ssFall;

  state_t      state_q;
  logic [3:0]  bitCnt_q;
  logic [6:0]  cmdShift_q;
  logic [7:0]  dataShift_q;
  logic [6:0]  readShift_q;
  logic        rw_q;
  logic [6:0]  addr_q;
  logic        skipFall_q;
  logic        commit_q;
  logic        miso_q;
  logic        wrStrobe_q;
  logic [6:0]  wrAddr_q;
  logic [7:0]  wrData_q;
  logic        frameErr_q;
  logic [7:0]  led_q;
  logic [7:0]  scratch_q;
  logic [7:0]  frameCnt_q;

  logic [7:0]  cmdNext_d;
  logic [7:0]  dataNext_d;
  logic [7:0]  readValue_d;
  logic        writable_d;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sclkSync_q <= '0;
      mosiSync_q <= '0;
      ssSync_q   <= '1;
      sclkPrev_q <= 1'b0;
      ssPrev_q   <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SPI_SCLK};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], SPI_MOSI};
      ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], SPI_SS_N};
      sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
      ssPrev_q   <= ssSync_q[SYNC_STAGES-1];
    end
  end

  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign ssS      = ssSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign ssRise   = ssS & ~ssPrev_q;
  assign ssFall   = ~ssS & ssPrev_q & armed_q;

  // The synchronizer reset value (SS_N high) would fake a falling edge if SS_N is
  // already low, so frames are only accepted after real SS_N-high samples are seen.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      settleCnt_q <= '0;
      armed_q     <= 1'b0;
    end else if (settleCnt_q != SW'(SETTLE)) begin
      settleCnt_q <= settleCnt_q + 1'b1;
    end else if (ssS && ssPrev_q) begin
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    cmdNext_d   = {cmdShift_q, mosiS};
    dataNext_d  = {dataShift_q[6:0], mosiS};
    readValue_d = 8'h00;
    if ({1'b0, cmdNext_d[6:0]} < NUM_REGS_B) begin
      case (cmdNext_d[6:0])
        7'd0:    readValue_d = ID_VALUE;
        7'd1:    readValue_d = led_q;
        7'd2:    readValue_d = scratch_q;
        7'd3:    readValue_d = frameCnt_q;
        default: readValue_d = 8'h00;
      endcase
    end
    writable_d = ((addr_q == 7'd1) || (addr_q == 7'd2)) && ({1'b0, addr_q} < NUM_REGS_B);
  end

  // Commit runs the cycle after DONE entry and the register update one cycle after
  // the strobe, so LED changes exactly one cycle after WR_STROBE.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= IDLE;
      bitCnt_q    <= 4'd0;
      cmdShift_q  <= 7'd0;
      dataShift_q <= 8'd0;
      readShift_q <= 7'd0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      skipFall_q  <= 1'b0;
      commit_q    <= 1'b0;
      miso_q      <= 1'b0;
      wrStrobe_q  <= 1'b0;
      wrAddr_q    <= 7'd0;
      wrData_q    <= 8'd0;
      frameErr_q  <= 1'b0;
      led_q       <= LED_RESET;
      scratch_q   <= 8'd0;
      frameCnt_q  <= 8'd0;
    end else begin
      wrStrobe_q <= 1'b0;
      frameErr_q <= 1'b0;
      commit_q   <= 1'b0;

      if (wrStrobe_q) begin
        case (wrAddr_q)
          7'd1:    led_q <= wrData_q;
          7'd2:    scratch_q <= wrData_q;
          default: ;
        endcase
      end

      if (commit_q) begin
        frameCnt_q <= frameCnt_q + 8'd1;
        if (!rw_q && writable_d) begin
          wrStrobe_q <= 1'b1;
          wrAddr_q   <= addr_q;
          wrData_q   <= dataShift_q;
        end
      end

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (ssFall) begin
            state_q  <= CMD;
            bitCnt_q <= 4'd0;
          end
        end

        CMD: begin
          if (ssRise) begin
            if (bitCnt_q != 4'd0) begin
              frameErr_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (sclkRise) begin
            cmdShift_q <= cmdNext_d[6:0];
            bitCnt_q   <= bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              rw_q       <= cmdNext_d[7];
              addr_q     <= cmdNext_d[6:0];
              skipFall_q <= 1'b1;
              state_q    <= DATA;
              if (cmdNext_d[7]) begin
                readShift_q <= readValue_d[6:0];
                miso_q      <= readValue_d[7];
              end
            end
          end
        end

        DATA: begin
          if (ssRise) begin
            frameErr_q <= 1'b1;
            miso_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (sclkRise) begin
            dataShift_q <= dataNext_d;
            bitCnt_q    <= bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd15) begin
              state_q  <= DONE;
              commit_q <= 1'b1;
            end
          end else if (sclkFall && rw_q) begin
            // Bit 7 is already on MISO; the fall that closes the command byte keeps it.
            if (skipFall_q) begin
              skipFall_q <= 1'b0;
            end else begin
              miso_q      <= readShift_q[6];
              readShift_q <= {readShift_q[5:0], 1'b0};
            end
          end
        end

        DONE: begin
          miso_q <= 1'b0;
          if (ssRise) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign SPI_MISO  = miso_q;
  assign LED       = led_q;
  assign WR_STROBE = wrStrobe_q;
  assign WR_ADDR   = wrAddr_q;
  assign WR_DATA   = wrData_q;
  assign FRAME_ERR = frameErr_q;

endmodule

// File: tb/tb_spi_led_slave.sv
// Bench for spi_led_slave: bit-banged SPI master plus a plain register-map model.
// Every scenario task compares the DUT against the model and counts the outcome.
module tb_spi_led_slave;

  localparam int HALF = 4;

  logic       CLOCK_50;
  logic       RESET;
  logic       SPI_SCLK;
  logic       SPI_MOSI;
  logic       SPI_SS_N;
  logic       SPI_MISO;
  logic [7:0] LED;
  logic       WR_STROBE;
  logic [6:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       FRAME_ERR;

  int assertCount = 0;
  int failCount   = 0;

  int         strobeCycles = 0;
  int         errCycles    = 0;
  logic [6:0] lastAddr     = '0;
  logic [7:0] lastData     = '0;
  logic [7:0] ledAtStrobe  = '0;
  logic [7:0] ledAfterStrobe = '0;
  logic       strobePrev   = 1'b0;

  logic [7:0] mLed;
  logic [7:0] mScratch;
  logic [7:0] mCnt;

  spi_led_slave dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .SPI_SCLK  (SPI_SCLK),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_SS_N  (SPI_SS_N),
    .SPI_MISO  (SPI_MISO),
    .LED       (LED),
    .WR_STROBE (WR_STROBE),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .FRAME_ERR (FRAME_ERR)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Records strobe and error pulses so scenarios can reason about counts and timing.
  always @(negedge CLOCK_50) begin
    if (strobePrev) ledAfterStrobe = LED;
    if (WR_STROBE) begin
      strobeCycles = strobeCycles + 1;
      lastAddr     = WR_ADDR;
      lastData     = WR_DATA;
      ledAtStrobe  = LED;
    end
    strobePrev = WR_STROBE;
    if (FRAME_ERR) errCycles = errCycles + 1;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  function automatic logic [7:0] modelRead(input logic [6:0] a);
    case (a)
      7'd0:    return 8'hA5;
      7'd1:    return mLed;
      7'd2:    return mScratch;
      7'd3:    return mCnt;
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelReset();
    mLed     = 8'h00;
    mScratch = 8'h00;
    mCnt     = 8'h00;
  endtask

  // A completed frame: reads see the old counter, then the counter moves on.
  task automatic modelCommit(input logic [7:0] cmd, input logic [7:0] data,
                             output logic [7:0] expRead, output bit expStrobe);
    logic [6:0] a;
    a         = cmd[6:0];
    expRead   = cmd[7] ? modelRead(a) : 8'h00;
    expStrobe = !cmd[7] && (a == 7'd1 || a == 7'd2);
    if (expStrobe && a == 7'd1) mLed = data;
    if (expStrobe && a == 7'd2) mScratch = data;
    mCnt = 8'((int'(mCnt) + 1) % 256);
  endtask

  // SPI mode-0 master: MOSI set while SCLK low, MISO captured just before each rise.
  task automatic applyStimulus(input logic [31:0] bits, input int nBits,
                               input bit endFrame, output logic [31:0] got);
    got      = '0;
    SPI_SS_N = 1'b0;
    waitCycles(6);
    for (int i = 0; i < nBits; i++) begin
      SPI_MOSI = bits[nBits-1-i];
      waitCycles(HALF);
      got      = {got[30:0], SPI_MISO};
      SPI_SCLK = 1'b1;
      waitCycles(HALF);
      SPI_SCLK = 1'b0;
    end
    waitCycles(HALF);
    if (endFrame) begin
      SPI_SS_N = 1'b1;
      waitCycles(10);
    end
  endtask

  task automatic doReset();
    RESET = 1'b1;
    waitCycles(3);
    RESET = 1'b0;
    modelReset();
    waitCycles(10);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    int s0, e0;
    SPI_SCLK = 1'b0;
    SPI_MOSI = 1'b0;
    SPI_SS_N = 1'b1;
    RESET    = 1'b1;
    waitCycles(3);
    assertCount++;
    if ({SPI_MISO, LED, WR_STROBE, WR_ADDR, WR_DATA, FRAME_ERR} !== 26'd0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got miso=%b led=%h strb=%b addr=%h data=%h err=%b, need all 0",
               SPI_MISO, LED, WR_STROBE, WR_ADDR, WR_DATA, FRAME_ERR);
    end
    RESET = 1'b0;
    modelReset();
    waitCycles(10);
    s0 = strobeCycles;
    e0 = errCycles;
    applyStimulus(32'h8000, 16, 1'b1, got);
    mCnt = mCnt + 8'd1;
    assertCount++;
    if (got[7:0] !== 8'hA5) begin
      failCount++;
      $display("[TB] FAIL read_id: got %h, need a5", got[7:0]);
    end
    assertCount++;
    if (strobeCycles - s0 !== 0 || errCycles - e0 !== 0) begin
      failCount++;
      $display("[TB] FAIL read_id_side: strobes %0d errs %0d, need 0 0", strobeCycles - s0, errCycles - e0);
    end
  endtask

  task automatic test_write_led();
    logic [31:0] got;
    logic [7:0]  expRead;
    bit          expStrobe;
    logic [7:0]  oldLed;
    int s0;
    oldLed = mLed;
    s0     = strobeCycles;
    applyStimulus(32'h013C, 16, 1'b1, got);
    modelCommit(8'h01, 8'h3C, expRead, expStrobe);
    assertCount++;
    if (strobeCycles - s0 !== 1 || lastAddr !== 7'd1 || lastData !== 8'h3C) begin
      failCount++;
      $display("[TB] FAIL write_led_strobe: cycles %0d addr %h data %h, need 1 01 3c",
               strobeCycles - s0, lastAddr, lastData);
    end
    assertCount++;
    if (ledAtStrobe !== oldLed || ledAfterStrobe !== 8'h3C) begin
      failCount++;
      $display("[TB] FAIL write_led_timing: led at strobe %h after %h, need %h 3c",
               ledAtStrobe, ledAfterStrobe, oldLed);
    end
    applyStimulus(32'h8100, 16, 1'b1, got);
    modelCommit(8'h81, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead || LED !== mLed) begin
      failCount++;
      $display("[TB] FAIL read_led: got %h led %h, need %h %h", got[7:0], LED, expRead, mLed);
    end
  endtask

  task automatic test_readonly();
    logic [31:0] got;
    logic [7:0]  expRead;
    bit          expStrobe;
    int s0;
    s0 = strobeCycles;
    applyStimulus(32'h00FF, 16, 1'b1, got);
    modelCommit(8'h00, 8'hFF, expRead, expStrobe);
    applyStimulus(32'h1055, 16, 1'b1, got);
    modelCommit(8'h10, 8'h55, expRead, expStrobe);
    assertCount++;
    if (strobeCycles - s0 !== 0) begin
      failCount++;
      $display("[TB] FAIL readonly_strobe: got %0d strobes, need 0", strobeCycles - s0);
    end
    applyStimulus(32'h8000, 16, 1'b1, got);
    modelCommit(8'h80, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead) begin
      failCount++;
      $display("[TB] FAIL readonly_id: got %h, need %h", got[7:0], expRead);
    end
    applyStimulus(32'h9000, 16, 1'b1, got);
    modelCommit(8'h90, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead) begin
      failCount++;
      $display("[TB] FAIL read_out_of_range: got %h, need %h", got[7:0], expRead);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got;
    logic [7:0]  expRead;
    bit          expStrobe;
    int s0, e0;
    s0 = strobeCycles;
    e0 = errCycles;
    applyStimulus(32'h0277 >> 5, 11, 1'b1, got);
    assertCount++;
    if (errCycles - e0 !== 1 || strobeCycles - s0 !== 0) begin
      failCount++;
      $display("[TB] FAIL abort_pulse: err cycles %0d strobes %0d, need 1 0", errCycles - e0, strobeCycles - s0);
    end
    applyStimulus(32'h8200, 16, 1'b1, got);
    modelCommit(8'h82, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead) begin
      failCount++;
      $display("[TB] FAIL abort_scratch: got %h, need %h", got[7:0], expRead);
    end
    applyStimulus(32'h8300, 16, 1'b1, got);
    modelCommit(8'h83, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead) begin
      failCount++;
      $display("[TB] FAIL abort_counter: got %h, need %h", got[7:0], expRead);
    end
    e0 = errCycles;
    applyStimulus(32'h0, 0, 1'b1, got);
    assertCount++;
    if (errCycles - e0 !== 0) begin
      failCount++;
      $display("[TB] FAIL empty_frame_err: got %0d err cycles, need 0", errCycles - e0);
    end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] got;
    logic [7:0]  expRead;
    bit          expStrobe;
    int          bad;
    doReset();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(32'h8200 | 32'($urandom_range(0, 255)), 16, 1'b1, got);
      modelCommit(8'h82, 8'h00, expRead, expStrobe);
      if (got[7:0] !== expRead) bad++;
    end
    assertCount++;
    if (bad !== 0) begin
      failCount++;
      $display("[TB] FAIL wrap_reads: %0d wrong scratch reads, need 0", bad);
    end
    applyStimulus(32'h8300, 16, 1'b1, got);
    modelCommit(8'h83, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== 8'h00 || expRead !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL wrap_zero: got %h, need 00", got[7:0]);
    end
    applyStimulus(32'h8300, 16, 1'b1, got);
    modelCommit(8'h83, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead) begin
      failCount++;
      $display("[TB] FAIL wrap_one: got %h, need %h", got[7:0], expRead);
    end
    applyStimulus((32'h8300 << 4) | 32'($urandom_range(0, 15)), 20, 1'b1, got);
    modelCommit(8'h83, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[11:4] !== expRead) begin
      failCount++;
      $display("[TB] FAIL long_frame_read: got %h, need %h", got[11:4], expRead);
    end
    applyStimulus(32'h8300, 16, 1'b1, got);
    modelCommit(8'h83, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead) begin
      failCount++;
      $display("[TB] FAIL long_frame_counts_once: got %h, need %h", got[7:0], expRead);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    logic [7:0]  cmd;
    logic [7:0]  data;
    logic [7:0]  expRead;
    bit          expStrobe;
    int s0, e0, badRead, badStrobe, badLed;
    badRead   = 0;
    badStrobe = 0;
    badLed    = 0;
    e0        = errCycles;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0:       cmd = 8'h00;
        1:       cmd = 8'h01;
        2:       cmd = 8'h02;
        3:       cmd = 8'h03;
        4:       cmd = 8'h10;
        default: cmd = 8'($urandom_range(0, 127));
      endcase
      cmd[7] = 1'($urandom_range(0, 1));
      data   = 8'($urandom_range(0, 255));
      s0     = strobeCycles;
      applyStimulus({16'h0, cmd, data}, 16, 1'b1, got);
      modelCommit(cmd, data, expRead, expStrobe);
      if (cmd[7] && got[7:0] !== expRead) badRead++;
      if ((strobeCycles - s0) !== (expStrobe ? 1 : 0)) badStrobe++;
      else if (expStrobe && (lastAddr !== cmd[6:0] || lastData !== data)) badStrobe++;
      if (LED !== mLed) badLed++;
    end
    assertCount++;
    if (badRead !== 0) begin
      failCount++;
      $display("[TB] FAIL random_reads: %0d wrong read bytes, need 0", badRead);
    end
    assertCount++;
    if (badStrobe !== 0) begin
      failCount++;
      $display("[TB] FAIL random_strobes: %0d wrong strobes, need 0", badStrobe);
    end
    assertCount++;
    if (badLed !== 0 || errCycles - e0 !== 0) begin
      failCount++;
      $display("[TB] FAIL random_led_err: %0d led mismatches %0d err cycles, need 0 0", badLed, errCycles - e0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] got;
    logic [7:0]  expRead;
    bit          expStrobe;
    int s0, e0;
    applyStimulus(32'h0166, 16, 1'b1, got);
    modelCommit(8'h01, 8'h66, expRead, expStrobe);
    s0 = strobeCycles;
    e0 = errCycles;
    applyStimulus(32'h01F0 >> 4, 12, 1'b0, got);
    RESET = 1'b1;
    waitCycles(2);
    RESET = 1'b0;
    modelReset();
    assertCount++;
    if (LED !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_midframe_led: got %h, need 00", LED);
    end
    applyStimulus(32'h0, 4, 1'b1, got);
    assertCount++;
    if (strobeCycles - s0 !== 0 || errCycles - e0 !== 0 || LED !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_midframe_ignored: strobes %0d errs %0d led %h, need 0 0 00",
               strobeCycles - s0, errCycles - e0, LED);
    end
    applyStimulus(32'h01C3, 16, 1'b1, got);
    modelCommit(8'h01, 8'hC3, expRead, expStrobe);
    assertCount++;
    if (strobeCycles - s0 !== 1 || LED !== mLed) begin
      failCount++;
      $display("[TB] FAIL after_reset_write: strobes %0d led %h, need 1 %h", strobeCycles - s0, LED, mLed);
    end
    applyStimulus(32'h8300, 16, 1'b1, got);
    modelCommit(8'h83, 8'h00, expRead, expStrobe);
    assertCount++;
    if (got[7:0] !== expRead) begin
      failCount++;
      $display("[TB] FAIL after_reset_counter: got %h, need %h", got[7:0], expRead);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    SPI_SCLK = 1'b0;
    SPI_MOSI = 1'b0;
    SPI_SS_N = 1'b1;
    modelReset();
    test_reset();
    test_write_led();
    test_readonly();
    test_abort();
    test_counter_wrap();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
